// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder: instruction memory responder for the program counter.
// Valid/ready request channel -> fixed-latency read pipeline -> 4-entry
// response FIFO -> valid/ready response channel. A credit count over the
// pipeline and FIFO keeps the FIFO from overflowing, so the pipeline never stalls.
// Optional feature macro: FETCH_FAULT_EN (out-of-range addresses fault instead
// of wrapping).
`timescale 1ns/1ps

module instr_fetch_responder #(
  parameter int ADDR_BITS  = 64,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_BITS-1:0]  req_addr,
  input  logic                  flush,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_instr,
  output logic [ADDR_BITS-1:0]  rsp_addr,
  output logic                  rsp_fault,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [31:0]           wr_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [31:0]           rd_instr;
  logic                  accept;
  logic [3:0]            outstanding;

  logic [LATENCY-1:0]    vld_p;
  logic [ADDR_BITS-1:0]  addr_p  [LATENCY];
  logic [31:0]           instr_p [LATENCY];

  logic [31:0]           fifo_instr [4];
  logic [ADDR_BITS-1:0]  fifo_addr  [4];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            fifo_cnt;
  logic                  push;
  logic                  pop;

  // Credits in use: every valid pipeline stage plus every buffered response.
  always_comb begin
    outstanding = {1'b0, fifo_cnt};
    for (int i = 0; i < LATENCY; i++) begin
      outstanding = outstanding + {3'b000, vld_p[i]};
    end
  end

  assign req_ready = rst & (outstanding < 4'd4);
  assign accept    = req_valid & req_ready;
  assign rd_idx    = req_addr[DEPTH_LOG2-1:0];

  // Program image load; a same-cycle read sees the previous word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Stage p0 boundary: array read in the accept cycle
`ifdef FETCH_FAULT_EN
  logic                  rd_fault;
  logic [LATENCY-1:0]    fault_p;
  logic [3:0]            fifo_fault;

  assign rd_fault = |req_addr[ADDR_BITS-1:DEPTH_LOG2];
  assign rd_instr = rd_fault ? 32'h0 : mem[rd_idx];

  // Fault flag travels with the data through pipeline and FIFO.
  always_ff @(posedge clk) begin
    fault_p[0] <= rd_fault;
    for (int i = 1; i < LATENCY; i++) begin
      fault_p[i] <= fault_p[i-1];
    end
    if (push) fifo_fault[wr_ptr] <= fault_p[LATENCY-1];
  end

  assign rsp_fault = rsp_valid & fifo_fault[rd_ptr];
`else
  assign rd_instr  = mem[rd_idx];
  assign rsp_fault = 1'b0;
`endif

  // Pipeline valids shift every cycle; flush kills older fetches but keeps a
  // branch-target request accepted in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1] & ~flush;
      end
    end
  end

  // Pipeline data shifts unconditionally; qualified by vld_p downstream.
  always_ff @(posedge clk) begin
    addr_p[0]  <= req_addr;
    instr_p[0] <= rd_instr;
    for (int i = 1; i < LATENCY; i++) begin
      addr_p[i]  <= addr_p[i-1];
      instr_p[i] <= instr_p[i-1];
    end
  end

  // Stage p(LATENCY) boundary: pipeline exit into the response FIFO
  assign push = vld_p[LATENCY-1] & ~flush;
  assign pop  = rsp_valid & rsp_ready;

  // FIFO pointers and occupancy; credit rule guarantees no overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
    end else if (flush) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b00, push} - {2'b00, pop};
    end
  end

  // FIFO storage written at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= instr_p[LATENCY-1];
      fifo_addr[wr_ptr]  <= addr_p[LATENCY-1];
    end
  end

  // Head outputs read zero whenever the FIFO is empty (including reset).
  assign rsp_valid = (fifo_cnt != 3'd0);
  assign rsp_instr = rsp_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign rsp_addr  = rsp_valid ? fifo_addr[rd_ptr]  : '0;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Scoreboard bench for instr_fetch_responder: stimulus pushes expected
// responses, an independent monitor pops and compares on each handshake.
`timescale 1ns/1ps

module tb_instr_fetch_responder;
  localparam int ADDR_BITS  = 64;
  localparam int DEPTH_LOG2 = 8;
  localparam int LATENCY    = 2;

  logic                  clk;
  logic                  rst;
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_BITS-1:0]  req_addr;
  logic                  flush;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_instr;
  logic [ADDR_BITS-1:0]  rsp_addr;
  logic                  rsp_fault;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [31:0]           wr_data;

  instr_fetch_responder #(
    .ADDR_BITS(ADDR_BITS), .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_addr(rsp_addr), .rsp_fault(rsp_fault),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] img [256];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          n_pop = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] prev_instr;
  logic [63:0] prev_addr;
  logic        prev_fault;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  task automatic flag(input string name, input string detail);
    total++;
    bad++;
    $display("FAIL %s: %s", name, detail);
  endtask

  function automatic exp_t mk(input logic [63:0] a, input int c);
    exp_t x;
    logic [7:0] idx;
    idx = a[7:0];
`ifdef FETCH_FAULT_EN
    x.fault = (a >= 64'd256);
`else
    x.fault = 1'b0;
`endif
    x.instr = x.fault ? 32'h0 : img[idx];
    x.addr  = a;
    x.cyc   = c;
    return x;
  endfunction

  // Monitor: stability while stalled, and scoreboard compare on each pop.
  always @(negedge clk) begin
    if (hold_prev && rst) begin
      chk("stable_instr", {32'h0, rsp_instr}, {32'h0, prev_instr});
      chk("stable_addr", rsp_addr, prev_addr);
      chk("stable_fault", {63'h0, rsp_fault}, {63'h0, prev_fault});
    end
    hold_prev  <= rsp_valid & ~rsp_ready & rst & ~flush;
    prev_instr <= rsp_instr;
    prev_addr  <= rsp_addr;
    prev_fault <= rsp_fault;
    if (rsp_valid && rsp_ready && rst) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        flag("unexpected_rsp", $sformatf("got addr %0h want no response", rsp_addr));
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_instr", {32'h0, rsp_instr}, {32'h0, mon_e.instr});
        chk("rsp_addr", rsp_addr, mon_e.addr);
        chk("rsp_fault", {63'h0, rsp_fault}, {63'h0, mon_e.fault});
        if (mon_e.cyc >= 0) chk("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Present one request (entered at posedge+1); returns at posedge+1 after accept.
  task automatic issue(input logic [63:0] a, input bit do_flush, input bit timed);
    int waited;
    int t;
    waited    = 0;
    req_valid = 1'b1;
    req_addr  = a;
    flush     = do_flush;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!req_ready) begin
      flag("accept_timeout", $sformatf("addr %0h never accepted", a));
      flush = 1'b0;
      return;
    end
    t = cyc;
    @(posedge clk);
    if (do_flush) exp_q.delete();
    exp_q.push_back(mk(a, timed ? t + 1 + LATENCY : -1));
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int nxt;
    int base;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    rsp_ready = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 256; i++) img[i] = 32'h0;

    #2 rst = 1'b0;
    #1;
    chk("reset_req_ready", {63'h0, req_ready}, 64'd0);
    chk("reset_rsp_valid", {63'h0, rsp_valid}, 64'd0);
    chk("reset_rsp_instr", {32'h0, rsp_instr}, 64'd0);
    chk("reset_rsp_addr", rsp_addr, 64'd0);
    chk("reset_rsp_fault", {63'h0, rsp_fault}, 64'd0);

    // Load program image while held in reset.
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      wr_en   = 1'b1;
      wr_addr = i[7:0];
      wr_data = 32'hF800_0000 + i;
      img[i]  = 32'hF800_0000 + i;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    chk("ready_in_reset", {63'h0, req_ready}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {63'h0, req_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Streaming: back-to-back with fixed latency and one response per cycle.
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) issue(i, 1'b0, 1'b1);
    req_valid = 1'b0;
    wait_drain("stream_drain");

    // Backpressure: four credits, then stall until the first pop.
    rsp_ready = 1'b0;
    acc = 0;
    nxt = 0;
    req_valid = 1'b1;
    for (int j = 0; j < 7; j++) begin
      req_addr = nxt;
      @(negedge clk);
      chk("bp_ready", {63'h0, req_ready}, {63'h0, (acc < 4)});
      if (req_ready) begin
        @(posedge clk);
        exp_q.push_back(mk(nxt, -1));
        acc++;
        nxt++;
      end else begin
        @(posedge clk);
      end
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    chk("bp_accepts", acc, 4);
    @(negedge clk);
    chk("bp_ready_full", {63'h0, req_ready}, 64'd0);
    chk("bp_valid_full", {63'h0, rsp_valid}, 64'd1);
    @(negedge clk);
    chk("bp_ready_after_pop", {63'h0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    wait_drain("bp_drain");

    // Flush: wrong-path fetches vanish, branch target survives.
    rsp_ready = 1'b0;
    issue(0, 1'b0, 1'b0);
    issue(1, 1'b0, 1'b0);
    issue(2, 1'b0, 1'b0);
    base = n_pop;
    issue(40, 1'b1, 1'b0);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_drain("flush_drain");
    repeat (4) @(posedge clk);
    #1;
    chk("flush_rsp_count", n_pop - base, 1);

    // Out-of-range address: fault or wrap depending on build.
    issue(256, 1'b0, 1'b1);
    issue(261, 1'b0, 1'b1);
    req_valid = 1'b0;
    wait_drain("range_drain");

    // Reset mid-stream with three requests outstanding.
    rsp_ready = 1'b0;
    issue(0, 1'b0, 1'b0);
    issue(1, 1'b0, 1'b0);
    issue(2, 1'b0, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", {63'h0, rsp_valid}, 64'd1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("async_reset_valid", {63'h0, rsp_valid}, 64'd0);
    chk("async_reset_ready", {63'h0, req_ready}, 64'd0);
    chk("async_reset_addr", rsp_addr, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_reset_idle", {63'h0, rsp_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    issue(7, 1'b0, 1'b1);
    req_valid = 1'b0;
    wait_drain("post_reset_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
